// File: rtl/entrada_antirrebote_pkg.sv
// -----------------------------------------------------------------------------
// entrada_antirrebote_pkg
//
// Shared definitions for the EDU-CIAA input conditioning blocks.
//
//   estado_t          : debounce FSM state encoding, shared by every input
//                       block built on the same debounce scheme.
//   aplicar_polaridad : maps a raw pin level onto "1 = pressed/active".
// -----------------------------------------------------------------------------
package entrada_antirrebote_pkg;

   // Debounce FSM states. The four encodings fill the 2-bit space, so the
   // state register can never hold a value outside this list.
   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } estado_t;

   // Returns the active-high view of a pin. Buttons wired to ground with a
   // pull-up read 0 when pressed, so they are inverted here.
   function automatic logic aplicar_polaridad(input logic activo_bajo,
                                              input logic nivel);
      logic resultado;
      if (activo_bajo) begin
         resultado = ~nivel;
      end else begin
         resultado = nivel;
      end
      return resultado;
   endfunction

endpackage

// File: rtl/entrada_antirrebote_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
//
// Two-flop synchronizer that brings an asynchronous pin level into the clk
// domain. Only the second flop is visible outside; the first flop may go
// metastable and must not feed any other logic.
//
// Ports:
//   clk   : destination clock
//   reset : asynchronous, active-low reset (both flops clear to 0)
//   d     : asynchronous input level
//   q     : synchronized level, two clk edges behind d
// -----------------------------------------------------------------------------
module sincronizador (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1_r;
   logic s2_r;

   // Two-stage shift of the asynchronous level into the clock domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= d;
         s2_r <= s1_r;
      end
   end

   assign q = s2_r;

endmodule

// File: rtl/entrada_antirrebote.sv
// -----------------------------------------------------------------------------
// entrada_antirrebote
//
// Input conditioner for a bouncy push-button / switch pin. The raw pin is
// polarity-corrected, synchronized with a 2-FF synchronizer and then
// debounced: a new level is accepted only after it has been seen on the
// synchronized signal for STABLE_CYCLES consecutive cycles. The clean level
// drives the sequence detector's w input.
//
// Parameters:
//   STABLE_CYCLES : consecutive synchronized cycles a new level must hold
//                   (>= 2). Default is 10 ms at 12 MHz.
//   ACTIVE_LOW    : 1 = pin reads 0 when pressed (inverted at the input),
//                   0 = pin used as-is.
//
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   btn_raw : raw asynchronous pin level
//   w       : debounced level, 1 = pressed/active (registered)
//   rise    : one-cycle strobe on the cycle w goes 0->1 (registered)
//   fall    : one-cycle strobe on the cycle w goes 1->0 (registered)
//
// Timing: with the input stable before sampling edge E0, w changes right
// after edge E0+STABLE_CYCLES+1 (two synchronizer edges plus STABLE_CYCLES
// counting edges, the first counting edge shared with the second sync edge).
// -----------------------------------------------------------------------------
module entrada_antirrebote
   import entrada_antirrebote_pkg::*;
#(
   parameter int STABLE_CYCLES = 120000,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic w,
   output logic rise,
   output logic fall
);

   // Counter width is derived from STABLE_CYCLES and is not meant to be set
   // from outside.
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_CERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_UNO  = {{(CNT_W-1){1'b0}}, 1'b1};
   // Last count value before the new level is accepted; the counter is
   // cleared on acceptance, so it never exceeds this value.
   localparam logic [CNT_W-1:0] CNT_FIN  = CNT_W'(STABLE_CYCLES - 1);

   logic             btn_in_s;
   logic             s2_s;
   estado_t          estado_r;
   logic [CNT_W-1:0] cnt_r;
   logic             w_r;
   logic             rise_r;
   logic             fall_r;

   assign btn_in_s = aplicar_polaridad(ACTIVE_LOW, btn_raw);

   sincronizador u_sincronizador (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in_s),
      .q     (s2_s)
   );

   // Debounce FSM with stability counter; all outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_r <= ST_LOW;
         cnt_r    <= CNT_CERO;
         w_r      <= 1'b0;
         rise_r   <= 1'b0;
         fall_r   <= 1'b0;
      end else begin
         // Strobes are single-cycle: cleared every cycle unless a level
         // change is accepted on this edge.
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         case (estado_r)
            ST_LOW: begin
               w_r <= 1'b0;
               if (s2_s) begin
                  // First sample of the new level already counts as one.
                  estado_r <= ST_WAIT_HIGH;
                  cnt_r    <= CNT_UNO;
               end else begin
                  cnt_r    <= CNT_CERO;
               end
            end
            ST_WAIT_HIGH: begin
               if (!s2_s) begin
                  // Level fell back before it was stable: glitch rejected.
                  estado_r <= ST_LOW;
                  cnt_r    <= CNT_CERO;
               end else if (cnt_r == CNT_FIN) begin
                  estado_r <= ST_HIGH;
                  cnt_r    <= CNT_CERO;
                  w_r      <= 1'b1;
                  rise_r   <= 1'b1;
               end else begin
                  cnt_r    <= cnt_r + CNT_UNO;
               end
            end
            ST_HIGH: begin
               w_r <= 1'b1;
               if (!s2_s) begin
                  estado_r <= ST_WAIT_LOW;
                  cnt_r    <= CNT_UNO;
               end else begin
                  cnt_r    <= CNT_CERO;
               end
            end
            ST_WAIT_LOW: begin
               if (s2_s) begin
                  estado_r <= ST_HIGH;
                  cnt_r    <= CNT_CERO;
               end else if (cnt_r == CNT_FIN) begin
                  estado_r <= ST_LOW;
                  cnt_r    <= CNT_CERO;
                  w_r      <= 1'b0;
                  fall_r   <= 1'b1;
               end else begin
                  cnt_r    <= cnt_r + CNT_UNO;
               end
            end
            default: begin
               // Corrupted state register: fall back to the idle state.
               estado_r <= ST_LOW;
               cnt_r    <= CNT_CERO;
               w_r      <= 1'b0;
            end
         endcase
      end
   end

   assign w    = w_r;
   assign rise = rise_r;
   assign fall = fall_r;

endmodule

// File: tb/tb_entrada_antirrebote.sv
// -----------------------------------------------------------------------------
// tb_entrada_antirrebote
//
// Directed bench for entrada_antirrebote with STABLE_CYCLES=4. The main
// instance (ACTIVE_LOW=0) is checked every cycle against a run-length model:
// the level seen by the debouncer is the pin delayed by two clock edges, and
// w flips once that delayed level has differed from w on STABLE_CYCLES
// consecutive edges. A second instance covers ACTIVE_LOW=1 with literal
// expectations. Inputs change on the falling edge, outputs are read there too.
// -----------------------------------------------------------------------------
module tb_entrada_antirrebote;

   localparam int S = 4;

   logic clk     = 1'b0;
   logic reset   = 1'b0;
   logic btn_raw = 1'b1;
   logic btn_raw2 = 1'b1;
   logic w, rise, fall;
   logic w2, rise2, fall2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   entrada_antirrebote #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw),
      .w       (w),
      .rise    (rise),
      .fall    (fall)
   );

   entrada_antirrebote #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut_al (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw2),
      .w       (w2),
      .rise    (rise2),
      .fall    (fall2)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Advance n rising edges and stop on the following falling edge.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Behavioural model: pin history two edges deep plus a run length of
   // samples that disagree with the current debounced level.
   logic h1, h2, wm, rm, fm;
   int   run;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         h1 <= 1'b0; h2 <= 1'b0; wm <= 1'b0; rm <= 1'b0; fm <= 1'b0; run <= 0;
      end else begin
         h1 <= btn_raw;
         h2 <= h1;
         rm <= 1'b0;
         fm <= 1'b0;
         if (h2 != wm) begin
            if (run + 1 == S) begin
               wm  <= ~wm;
               rm  <= ~wm;
               fm  <= wm;
               run <= 0;
            end else begin
               run <= run + 1;
            end
         end else begin
            run <= 0;
         end
      end
   end

   // Cycle-by-cycle comparison of the main instance against the model.
   always @(negedge clk) begin
      chk("model_w", w, wm);
      chk("model_rise", rise, rm);
      chk("model_fall", fall, fm);
      chk("no_rise_and_fall", rise & fall, 1'b0);
   end

   initial begin
      // 1. Reset held low with the input active; held through release.
      btn_raw  = 1'b1;
      btn_raw2 = 1'b1;
      reset    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_w", w, 1'b0);
         chk("rst_rise", rise, 1'b0);
         chk("rst_fall", fall, 1'b0);
      end
      reset = 1'b1;
      edges(5);
      chk("t1_w_before_E5", w, 1'b0);
      edges(1);
      chk("t1_w_after_E5", w, 1'b1);
      chk("t1_rise_after_E5", rise, 1'b1);
      edges(1);
      chk("t1_rise_one_cycle", rise, 1'b0);
      chk("t1_w_held", w, 1'b1);
      chk("t1_al_idle", w2, 1'b0);

      // 4. Release the input: fall after E5.
      btn_raw = 1'b0;
      edges(5);
      chk("t4_w_before_E5", w, 1'b1);
      edges(1);
      chk("t4_w_after_E5", w, 1'b0);
      chk("t4_fall", fall, 1'b1);
      chk("t4_no_rise", rise, 1'b0);
      edges(1);
      chk("t4_fall_one_cycle", fall, 1'b0);

      // 2. Two-cycle pulse is rejected.
      btn_raw = 1'b1;
      edges(2);
      btn_raw = 1'b0;
      edges(8);
      chk("t2_short_pulse_w", w, 1'b0);

      // 3. Bounce 1,0,1,0 then held 1.
      btn_raw = 1'b1; edges(1);
      btn_raw = 1'b0; edges(1);
      btn_raw = 1'b1; edges(1);
      btn_raw = 1'b0; edges(1);
      btn_raw = 1'b1;
      edges(5);
      chk("t3_w_before_E5", w, 1'b0);
      edges(1);
      chk("t3_w_after_E5", w, 1'b1);
      chk("t3_rise", rise, 1'b1);
      edges(1);
      chk("t3_rise_one_cycle", rise, 1'b0);

      // 5. Active-low instance: press (1->0) and release.
      btn_raw2 = 1'b0;
      edges(5);
      chk("t5_w_before_E5", w2, 1'b0);
      edges(1);
      chk("t5_w_after_E5", w2, 1'b1);
      chk("t5_rise", rise2, 1'b1);
      edges(1);
      chk("t5_rise_one_cycle", rise2, 1'b0);
      btn_raw2 = 1'b1;
      edges(5);
      chk("t5_w_before_release", w2, 1'b1);
      edges(1);
      chk("t5_w_released", w2, 1'b0);
      chk("t5_fall", fall2, 1'b1);

      // 6a. Asynchronous reset while w=1 clears w before any clock edge.
      edges(1);
      chk("t6_w_high_before_reset", w, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_w", w, 1'b0);
      chk("t6_async_rise", rise, 1'b0);
      chk("t6_async_fall", fall, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      edges(5);
      chk("t6_rerun_before_E5", w, 1'b0);
      edges(1);
      chk("t6_rerun_after_E5", w, 1'b1);
      chk("t6_rerun_rise", rise, 1'b1);

      // 6b. Reset mid-count in ST_WAIT_LOW (cnt=2): w clears, no strobe later.
      btn_raw = 1'b0;
      edges(4);
      chk("t6_midcount_w", w, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("t6_midcount_async_w", w, 1'b0);
      chk("t6_midcount_async_fall", fall, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      edges(8);
      chk("t6_after_release_w", w, 1'b0);
      chk("t6_after_release_fall", fall, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
